// File: rtl/poly_osc_mixer_pkg.sv
// Shared definitions for the polyphonic oscillator bank.
//   - waveform codes carried on cfg_wave and into the wave shaper
//   - volt_t / POLY_SAMPLE_T: signed sample types (fixed 16-bit and width-parametric)
//   - state_t: sequencer states of the time-multiplexed voice loop
`ifndef POLY_OSC_MIXER_PKG_SV
`define POLY_OSC_MIXER_PKG_SV

// Signed sample of arbitrary width, for parametric ports and signals.
`define POLY_SAMPLE_T(w) logic signed [(w)-1:0]

package poly_osc_mixer_pkg;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_MUTE   = 2'd3;

    localparam int VOLT_W = 16;
    typedef logic signed [VOLT_W-1:0] volt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/poly_osc_mixer_wave_shaper.sv
// Combinational phase-to-sample shaper, shared by all voices.
// Ports:
//   p_i      in   SAMPLE_W  top bits of the voice phase (unsigned)
//   wave_i   in   2         waveform code (saw, square, triangle, mute)
//   sample_o out  SAMPLE_W  signed sample
module poly_osc_mixer_wave_shaper
    import poly_osc_mixer_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0]   p_i,
    input  logic [1:0]            wave_i,
    output `POLY_SAMPLE_T(SAMPLE_W) sample_o
);

    localparam logic [SAMPLE_W-1:0] H      = {1'b1, {(SAMPLE_W-1){1'b0}}};
    // +(H-1) and -(H-1) in two's complement
    localparam logic [SAMPLE_W-1:0] SQ_POS = ~H;
    localparam logic [SAMPLE_W-1:0] SQ_NEG = H | SAMPLE_W'(1);

    // Triangle: fold the second half of the cycle back down, then double.
    // The MSB of the folded value is always 0, so only the low bits are kept.
    logic [SAMPLE_W-2:0] fold;

    always_comb begin
        fold = p_i[SAMPLE_W-1] ? ~p_i[SAMPLE_W-2:0] : p_i[SAMPLE_W-2:0];
        case (wave_i)
            WAVE_SAW:    sample_o = p_i ^ H;
            WAVE_SQUARE: sample_o = p_i[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
            WAVE_TRI:    sample_o = {fold, 1'b0} ^ H;
            default:     sample_o = '0;
        endcase
    end

endmodule

// File: rtl/poly_osc_mixer.sv
// Time-multiplexed polyphonic oscillator bank and mixer.
// Once per SAMPLE_DIV cycles every enabled voice advances its phase,
// the shared shaper converts it to a sample, the samples are summed and
// the mixed result is presented on voltage with a one-cycle dv strobe.
// Ports:
//   clk        in   1          system clock
//   rst        in   1          asynchronous active-high reset
//   cfg_we     in   1          voice configuration write strobe
//   cfg_voice  in   VIDX_W     voice index to write
//   cfg_inc    in   PHASE_W    phase increment per sample (unsigned)
//   cfg_wave   in   2          waveform code
//   cfg_en     in   1          voice enable
//   voltage    out  SAMPLE_W   mixed signed sample, held between strobes
//   dv         out  1          one-cycle pulse when voltage updates
//   busy       out  1          high while voices are being processed/mixed
module poly_osc_mixer
    import poly_osc_mixer_pkg::*;
#(
    parameter int  NUM_VOICES = 4,
    parameter int  PHASE_W    = 24,
    parameter int  SAMPLE_W   = 16,
    parameter int  SAMPLE_DIV = 520,
    parameter int  MIX_MODE   = 0,
    localparam int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [VIDX_W-1:0]          cfg_voice,
    input  logic [PHASE_W-1:0]         cfg_inc,
    input  logic [1:0]                 cfg_wave,
    input  logic                       cfg_en,
    output logic signed [SAMPLE_W-1:0] voltage,
    output logic                       dv,
    output logic                       busy
);

    localparam int LOG2N = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + LOG2N;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [VIDX_W-1:0]        VIDX_LAST = VIDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MAX   = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN   = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    // Scale (mode 0) or clamp (mode 1) the voice sum down to the output width.
    function automatic logic signed [SAMPLE_W-1:0] mix(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] shifted;
        shifted = a >>> LOG2N;
        if (MIX_MODE == 0) begin
            return shifted[SAMPLE_W-1:0];
        end
        if (a > ACC_MAX) begin
            return ACC_MAX[SAMPLE_W-1:0];
        end
        if (a < ACC_MIN) begin
            return ACC_MIN[SAMPLE_W-1:0];
        end
        return a[SAMPLE_W-1:0];
    endfunction

    // Voice configuration and phase storage
    logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
    logic [1:0]         wave_q  [NUM_VOICES];
    logic               en_q    [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_d [NUM_VOICES];

    // Sequencer state
    logic [DIV_W-1:0]          div_q;
    state_t                    state_q, state_d;
    logic [VIDX_W-1:0]         vidx_q, vidx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] voltage_q, voltage_d;
    logic                      dv_q, dv_d;

    // Datapath for the voice currently selected by vidx_q
    logic [PHASE_W-1:0]         phase_sum;
    logic signed [SAMPLE_W-1:0] shaped;
    logic signed [ACC_W-1:0]    shaped_ext;

    assign phase_sum  = phase_q[vidx_q] + inc_q[vidx_q];
    assign shaped_ext = ACC_W'(shaped);

    poly_osc_mixer_wave_shaper #(
        .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
        .p_i      (phase_sum[PHASE_W-1 -: SAMPLE_W]),
        .wave_i   (wave_q[vidx_q]),
        .sample_o (shaped)
    );

    // Free-running sample divider; the FSM never stalls it, which keeps
    // the dv period exactly SAMPLE_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Configuration writes never touch the phase, so retuning is click-free.
    // A write landing in the same cycle its voice is processed is seen only
    // from the next sample on, since processing reads the registered values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc_q[i]  <= '0;
                wave_q[i] <= '0;
                en_q[i]   <= 1'b0;
            end
        end else if (cfg_we) begin
            inc_q[cfg_voice]  <= cfg_inc;
            wave_q[cfg_voice] <= cfg_wave;
            en_q[cfg_voice]   <= cfg_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vidx_q    <= '0;
            acc_q     <= '0;
            voltage_q <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vidx_q    <= vidx_d;
            acc_q     <= acc_d;
            voltage_q <= voltage_d;
            dv_q      <= dv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vidx_d    = vidx_q;
        acc_d     = acc_q;
        voltage_d = voltage_q;
        dv_d      = 1'b0;
        phase_d   = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (div_q == DIV_LAST) begin
                    state_d = ST_ACCUM;
                    vidx_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_ACCUM: begin
                // Disabled voices hold their phase and contribute nothing.
                if (en_q[vidx_q]) begin
                    phase_d[vidx_q] = phase_sum;
                    acc_d           = acc_q + shaped_ext;
                end
                if (vidx_q == VIDX_LAST) begin
                    state_d = ST_OUT;
                end else begin
                    vidx_d = vidx_q + VIDX_W'(1);
                end
            end
            ST_OUT: begin
                voltage_d = mix(acc_q);
                dv_d      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign voltage = voltage_q;
    assign dv      = dv_q;
    assign busy    = (state_q == ST_ACCUM) || (state_q == ST_OUT);

endmodule

// File: tb/tb_poly_osc_mixer.sv
module tb_poly_osc_mixer;
    import poly_osc_mixer_pkg::*;

    localparam int N   = 4;
    localparam int PW  = 24;
    localparam int SW  = 16;
    localparam int DIV = 520;
    localparam int H   = 32768;
    localparam int LIM = 2 * DIV + 20;
    localparam int FIRST_DV = DIV - 1 + N + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [PW-1:0] cfg_inc = '0;
    logic [1:0]  cfg_wave = '0;
    logic        cfg_en = 1'b0;
    logic signed [SW-1:0] v0, v1;
    logic        dv0, dv1, busy0, busy1;

    always #20 clk = ~clk;

    poly_osc_mixer #(.NUM_VOICES(N), .PHASE_W(PW), .SAMPLE_W(SW), .SAMPLE_DIV(DIV), .MIX_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
        .cfg_wave(cfg_wave), .cfg_en(cfg_en), .voltage(v0), .dv(dv0), .busy(busy0));

    poly_osc_mixer #(.NUM_VOICES(N), .PHASE_W(PW), .SAMPLE_W(SW), .SAMPLE_DIV(DIV), .MIX_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
        .cfg_wave(cfg_wave), .cfg_en(cfg_en), .voltage(v1), .dv(dv1), .busy(busy1));

    always @(posedge clk) begin
        if (cfg_we) assert (int'(cfg_voice) < N) else $error("cfg_voice out of range: %0d", cfg_voice);
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the voice bank, one step per output sample
    int unsigned m_phase [N];
    int unsigned m_inc   [N];
    int          m_wave  [N];
    bit          m_en    [N];
    int          exp_q0[$];
    int          exp_q1[$];

    function automatic int shape_ref(input int unsigned ph, input int w);
        int p;
        p = int'(ph >> (PW - SW));
        case (w)
            0:       return p - H;
            1:       return (p < H) ? (H - 1) : -(H - 1);
            2:       return (p < H) ? (2 * p - H) : (2 * (65535 - p) - H);
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int acc, m0, m1;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                m_phase[i] = (m_phase[i] + m_inc[i]) & 32'h00FF_FFFF;
                acc += shape_ref(m_phase[i], m_wave[i]);
            end
        end
        m0 = (acc >= 0) ? acc / N : -((-acc + N - 1) / N);
        m1 = (acc > H - 1) ? H - 1 : ((acc < -H) ? -H : acc);
        exp_q0.push_back(m0);
        exp_q1.push_back(m1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_phase[i] = 0; m_inc[i] = 0; m_wave[i] = 0; m_en[i] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_voice(input int v, input int unsigned inc, input int w, input bit en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_inc = PW'(inc); cfg_wave = 2'(w); cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
        m_inc[v] = inc; m_wave[v] = w; m_en[v] = en;
    endtask

    // Counts negedges until dv0 is seen high, bounded by limit.
    task automatic wait_dv(input int limit, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (dv0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n, e0, e1; bit ok;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        n_checks++;
        if (v0 !== 0 || v1 !== 0 || dv0 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            $display("FAIL reset_state: v0=%0d v1=%0d dv=%0b busy=%0b/%0b, required all 0", v0, v1, dv0, busy0, busy1);
        end else n_pass++;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            model_step();
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || n !== ((s == 0) ? FIRST_DV : DIV) || dv1 !== 1'b1) begin
                $display("FAIL reset_cadence[%0d]: dv after %0d cycles (seen=%0b dv1=%0b), required %0d", s, n, ok, dv1, (s == 0) ? FIRST_DV : DIV);
            end else n_pass++;
            n_checks++;
            if (int'(v0) !== e0 || int'(v1) !== e1) begin
                $display("FAIL reset_voltage[%0d]: got %0d/%0d, required %0d/%0d", s, v0, v1, e0, e1);
            end else n_pass++;
        end
        // The sample period ends at cycle T (IDLE), processing runs from T+1
        repeat (DIV - N - 2) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0) $display("FAIL busy_idle: got %0b, required 0", busy0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1) $display("FAIL busy_accum: got %0b, required 1", busy0);
        else n_pass++;
        model_step();
        wait_dv(LIM, n, ok);
        e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
        n_checks++;
        if (!ok || n !== N + 1 || busy0 !== 1'b0) begin
            $display("FAIL dv_latency: dv %0d cycles after ACCUM start (seen=%0b busy=%0b), required %0d and busy 0", n, ok, busy0, N + 1);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dv0 !== 1'b0 || dv1 !== 1'b0) $display("FAIL dv_pulse_width: dv still %0b/%0b, required 0", dv0, dv1);
        else n_pass++;
    endtask

    task automatic test_saw();
        int n, e0, e1; bit ok;
        logic signed [SW-1:0] want [2];
        want[0] = 16'shE040; want[1] = 16'shE080;
        do_reset();
        set_voice(0, 32'h010000, WAVE_SAW, 1'b1);
        for (int s = 0; s < 2; s++) begin
            model_step();
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || int'(v0) !== e0 || int'(v1) !== e1 || v0 !== want[s]) begin
                $display("FAIL saw[%0d]: got %0d/%0d (seen=%0b), required %0d/%0d", s, v0, v1, ok, e0, e1);
            end else n_pass++;
        end
    endtask

    task automatic test_square();
        int n, e0, e1; bit ok;
        int want0 [3];
        int want1 [3];
        want0[0] = 32767;  want1[0] = 32767;
        want0[1] = -32767; want1[1] = -32768;
        want0[2] = -32767; want1[2] = -32768;
        do_reset();
        for (int v = 0; v < N; v++) set_voice(v, 0, WAVE_SQUARE, 1'b1);
        for (int s = 0; s < 3; s++) begin
            if (s == 1) for (int v = 0; v < N; v++) set_voice(v, 32'h800000, WAVE_SQUARE, 1'b1);
            if (s == 2) for (int v = 0; v < N; v++) set_voice(v, 0, WAVE_SQUARE, 1'b1);
            model_step();
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || int'(v0) !== e0 || int'(v1) !== e1 || int'(v0) !== want0[s] || int'(v1) !== want1[s]) begin
                $display("FAIL square[%0d]: got %0d/%0d (seen=%0b), required %0d/%0d", s, v0, v1, ok, e0, e1);
            end else n_pass++;
        end
    endtask

    task automatic test_triangle();
        int n, e0, e1, errs; bit ok;
        do_reset();
        set_voice(1, 32'h400000, WAVE_TRI, 1'b1);
        errs = 0;
        for (int s = 0; s < 64; s++) begin
            model_step();
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || int'(v0) !== e0 || int'(v1) !== e1) begin
                errs++;
                if (errs <= 4) $display("FAIL triangle[%0d]: got %0d/%0d (seen=%0b), required %0d/%0d", s, v0, v1, ok, e0, e1);
            end else n_pass++;
        end
    endtask

    task automatic test_retune();
        int n, e0, e1; bit ok;
        do_reset();
        set_voice(2, 32'h010000, WAVE_SAW, 1'b1);
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin
                // Land the write in the cycle voice 2 is processed (T+3)
                repeat (DIV - N - 2 + 3) @(negedge clk);
                model_step();
                cfg_we = 1'b1; cfg_voice = 2'd2; cfg_inc = 24'h020000; cfg_wave = WAVE_SAW; cfg_en = 1'b1;
                n_checks++;
                if (busy0 !== 1'b1) $display("FAIL retune_window: busy=%0b, required 1", busy0);
                else n_pass++;
                @(negedge clk);
                cfg_we = 1'b0;
                m_inc[2] = 32'h020000;
            end else begin
                if (s == 3) set_voice(2, 32'h020000, WAVE_SAW, 1'b0);
                if (s == 4) set_voice(2, 32'h020000, WAVE_SAW, 1'b1);
                model_step();
            end
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || int'(v0) !== e0 || int'(v1) !== e1 || (s == 3 && v0 !== 0)) begin
                $display("FAIL retune[%0d]: got %0d/%0d (seen=%0b), required %0d/%0d", s, v0, v1, ok, e0, e1);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_accum();
        int n, e0, e1; bit ok, bad;
        do_reset();
        set_voice(0, 32'h010000, WAVE_SAW, 1'b1);
        for (int s = 0; s < 2; s++) begin
            model_step();
            wait_dv(LIM, n, ok);
            e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
            n_checks++;
            if (!ok || int'(v0) !== e0) $display("FAIL pre_reset[%0d]: got %0d (seen=%0b), required %0d", s, v0, ok, e0);
            else n_pass++;
        end
        repeat (DIV - N - 2 + 2) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1) $display("FAIL mid_accum_window: busy=%0b, required 1", busy0);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (v0 !== 0 || v1 !== 0 || dv0 !== 1'b0 || busy0 !== 1'b0) begin
            $display("FAIL async_reset: v=%0d/%0d dv=%0b busy=%0b, required all 0", v0, v1, dv0, busy0);
        end else n_pass++;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dv0 !== 1'b0 || dv1 !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL reset_no_dv: dv seen during reset, required none");
        else n_pass++;
        clear_model();
        rst = 1'b0;
        model_step();
        wait_dv(LIM, n, ok);
        e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
        n_checks++;
        if (!ok || n !== FIRST_DV || int'(v0) !== e0 || int'(v1) !== e1) begin
            $display("FAIL restart_cadence: dv after %0d cycles v=%0d/%0d (seen=%0b), required %0d and %0d/%0d", n, v0, v1, ok, FIRST_DV, e0, e1);
        end else n_pass++;
        set_voice(0, 32'h010000, WAVE_SAW, 1'b1);
        model_step();
        wait_dv(LIM, n, ok);
        e0 = exp_q0.pop_front(); e1 = exp_q1.pop_front();
        n_checks++;
        if (!ok || int'(v0) !== e0 || v0 !== 16'shE040) begin
            $display("FAIL phase_cleared: got %0d (seen=%0b), required %0d", v0, ok, e0);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_saw();
        test_square();
        test_triangle();
        test_retune();
        test_reset_mid_accum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
